// File: rtl/a2d_pkg.sv
// Shared types and command-format constants for the A2D SPI responder.
// The command word is built here so that the FSM and the bench agree on its layout.
package a2d_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TXN1,
      DEAD,
      TXN2,
      DONE
   } a2d_state_e;

   localparam logic [1:0]  CMD_PAD_HI = 2'b00;
   localparam logic [10:0] CMD_PAD_LO = 11'h000;

   localparam logic [2:0] CH0 = 3'd0;
   localparam logic [2:0] CH1 = 3'd1;
   localparam logic [2:0] CH2 = 3'd2;
   localparam logic [2:0] CH3 = 3'd3;
   localparam logic [2:0] CH4 = 3'd4;
   localparam logic [2:0] CH5 = 3'd5;
   localparam logic [2:0] CH6 = 3'd6;
   localparam logic [2:0] CH7 = 3'd7;

   function automatic logic [15:0] build_cmd(input logic [2:0] ch);
      return {CMD_PAD_HI, ch, CMD_PAD_LO};
   endfunction

endpackage

// File: rtl/a2d_spi_intf_if.sv
// Conversion request/result handshake between the motion controller and the A2D responder.
interface a2d_spi_intf_if;

   logic        strt_cnv;
   logic [2:0]  chnnl;
   logic        cnv_cmplt;
   logic [11:0] res;

   modport master (
      output strt_cnv,
      output chnnl,
      input  cnv_cmplt,
      input  res
   );

   modport slave (
      input  strt_cnv,
      input  chnnl,
      output cnv_cmplt,
      output res
   );

endinterface

// File: rtl/spi_mstr16.sv
// Single 16-bit SPI transaction master: SCLK idles high, MOSI shifts on SCLK fall,
// MISO is sampled on SCLK rise. done_o pulses combinationally on the edge SS_n rises.
module spi_mstr16 #(
   parameter int unsigned SCLK_DIV_W = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt_i,
   input  logic [15:0] cmd_i,
   output logic        done_o,
   output logic [15:0] rd_data_o,
   output logic        SS_n_o,
   output logic        SCLK_o,
   output logic        MOSI_o,
   input  logic        MISO_i
);

   // Divider start point leaves a 9-clk front porch before the first SCLK fall.
   localparam logic [SCLK_DIV_W-1:0] DIV_LOAD  = SCLK_DIV_W'((1 << SCLK_DIV_W) - 9);
   localparam logic [SCLK_DIV_W-1:0] DIV_RISE  = SCLK_DIV_W'((1 << (SCLK_DIV_W - 1)) - 1);
   localparam logic [SCLK_DIV_W-1:0] DIV_SHIFT = '1;

   logic                  active_q, active_d;
   logic                  ss_n_q, ss_n_d;
   logic                  sclk_q, sclk_d;
   logic                  miso_q, miso_d;
   logic [SCLK_DIV_W-1:0] div_q, div_d;
   logic [4:0]            edge_cnt_q, edge_cnt_d;
   logic [15:0]           shift_q, shift_d;

   always_comb begin
      active_d   = active_q;
      ss_n_d     = ss_n_q;
      miso_d     = miso_q;
      div_d      = div_q;
      edge_cnt_d = edge_cnt_q;
      shift_d    = shift_q;
      done_o     = 1'b0;

      if (!active_q) begin
         if (wrt_i) begin
            active_d   = 1'b1;
            ss_n_d     = 1'b0;
            div_d      = DIV_LOAD;
            edge_cnt_d = '0;
            shift_d    = cmd_i;
         end
      end else begin
         div_d = div_q + 1'b1;
         if (div_q == DIV_RISE) begin
            miso_d     = MISO_i;
            edge_cnt_d = edge_cnt_q + 5'd1;
         end
         // The all-ones point before the first rise is the front porch end, not a shift.
         if ((div_q == DIV_SHIFT) && (edge_cnt_q != '0)) begin
            shift_d = {shift_q[14:0], miso_q};
            if (edge_cnt_q == 5'd16) begin
               done_o     = 1'b1;
               active_d   = 1'b0;
               ss_n_d     = 1'b1;
               div_d      = '0;
               edge_cnt_d = '0;
            end
         end
      end

      sclk_d = active_d ? div_d[SCLK_DIV_W-1] : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active_q   <= 1'b0;
         ss_n_q     <= 1'b1;
         sclk_q     <= 1'b1;
         miso_q     <= 1'b0;
         div_q      <= '0;
         edge_cnt_q <= '0;
         shift_q    <= '0;
      end else begin
         active_q   <= active_d;
         ss_n_q     <= ss_n_d;
         sclk_q     <= sclk_d;
         miso_q     <= miso_d;
         div_q      <= div_d;
         edge_cnt_q <= edge_cnt_d;
         shift_q    <= shift_d;
      end
   end

   assign rd_data_o = {shift_q[14:0], miso_q};
   assign SS_n_o    = ss_n_q;
   assign SCLK_o    = sclk_q;
   assign MOSI_o    = shift_q[15];

endmodule

// File: rtl/a2d_spi_intf.sv
// A2D conversion responder: on strt_cnv runs a command transaction, a dead gap,
// then a read transaction, and latches the 12-bit result with a sticky cnv_cmplt.
module a2d_spi_intf
   import a2d_pkg::*;
#(
   parameter int unsigned SCLK_DIV_W = 5,
   parameter int unsigned DEAD_CLKS  = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   a2d_spi_intf_if.slave a2d,
   output logic         SS_n,
   output logic         SCLK,
   output logic         MOSI,
   input  logic         MISO
);

   localparam int unsigned DW = (DEAD_CLKS > 1) ? $clog2(DEAD_CLKS) : 1;

   a2d_state_e  state_q, state_d;
   logic [2:0]  chnnl_q, chnnl_d;
   logic [DW-1:0] dead_cnt_q, dead_cnt_d;
   logic        cnv_cmplt_q, cnv_cmplt_d;
   logic [11:0] res_q, res_d;

   logic        wrt;
   logic [15:0] cmd;
   logic        done;
   logic [15:0] rd_data;
   logic        unused_rd_hi;

   spi_mstr16 #(
      .SCLK_DIV_W(SCLK_DIV_W)
   ) u_spi (
      .clk       (clk),
      .rst_n     (rst_n),
      .wrt_i     (wrt),
      .cmd_i     (cmd),
      .done_o    (done),
      .rd_data_o (rd_data),
      .SS_n_o    (SS_n),
      .SCLK_o    (SCLK),
      .MOSI_o    (MOSI),
      .MISO_i    (MISO)
   );

   always_comb begin
      state_d     = state_q;
      chnnl_d     = chnnl_q;
      dead_cnt_d  = dead_cnt_q;
      cnv_cmplt_d = cnv_cmplt_q;
      res_d       = res_q;
      wrt         = 1'b0;
      cmd         = build_cmd(chnnl_q);

      case (state_q)
         IDLE, DONE: begin
            if (a2d.strt_cnv) begin
               // chnnl_q is not loaded yet on this edge, so the command uses the live input.
               chnnl_d     = a2d.chnnl;
               cmd         = build_cmd(a2d.chnnl);
               wrt         = 1'b1;
               cnv_cmplt_d = 1'b0;
               state_d     = TXN1;
            end
         end
         TXN1: begin
            if (done) begin
               dead_cnt_d = '0;
               state_d    = DEAD;
            end
         end
         DEAD: begin
            if (dead_cnt_q == DW'(DEAD_CLKS - 1)) begin
               wrt        = 1'b1;
               dead_cnt_d = '0;
               state_d    = TXN2;
            end else begin
               dead_cnt_d = dead_cnt_q + 1'b1;
            end
         end
         TXN2: begin
            if (done) begin
               res_d       = rd_data[11:0];
               cnv_cmplt_d = 1'b1;
               state_d     = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         chnnl_q     <= '0;
         dead_cnt_q  <= '0;
         cnv_cmplt_q <= 1'b0;
         res_q       <= '0;
      end else begin
         state_q     <= state_d;
         chnnl_q     <= chnnl_d;
         dead_cnt_q  <= dead_cnt_d;
         cnv_cmplt_q <= cnv_cmplt_d;
         res_q       <= res_d;
      end
   end

   assign unused_rd_hi  = ^rd_data[15:12];
   assign a2d.cnv_cmplt = cnv_cmplt_q;
   assign a2d.res       = res_q;

endmodule

// File: tb/tb_a2d_spi_intf.sv
// Self-checking bench for a2d_spi_intf: an ADC model answers on MISO, a waveform
// monitor records each SPI transaction, and scenario tasks compare against expectations.
module tb_a2d_spi_intf;

   localparam int SCLK_DIV_W = 5;
   localparam int DEAD_CLKS  = 32;
   localparam int PERIOD     = 1 << SCLK_DIV_W;
   localparam int PORCH      = 9;
   localparam int TXN_CLKS   = PORCH + 16 * PERIOD;
   localparam int CONV_LAT   = 2 * TXN_CLKS + DEAD_CLKS;

   typedef struct {
      int          len;
      int          rises;
      int          porch;
      logic [15:0] mosi;
      int          bad_period;
      int          unstable;
      int          gap;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic SS_n, SCLK, MOSI;
   logic miso_drv = 1'b0;

   a2d_spi_intf_if a2d_if ();

   a2d_spi_intf #(
      .SCLK_DIV_W(SCLK_DIV_W),
      .DEAD_CLKS (DEAD_CLKS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a2d   (a2d_if),
      .SS_n  (SS_n),
      .SCLK  (SCLK),
      .MOSI  (MOSI),
      .MISO  (miso_drv)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ADC model and waveform monitor
   txn_t        txq[$];
   txn_t        cur;
   logic [15:0] adc_w1 = '0, adc_w2 = '0, adc_word = '0;
   logic        prev_ss = 1'b1, prev_sc = 1'b1, prev_mosi = 1'b0, phase = 1'b0;
   int          txn_start = 0, ss_rise_cyc = 0, last_rise = -1, fall_idx = 0;
   int          idle_toggles = 0, ss_falls = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ss = 1'b1;
         prev_sc = 1'b1;
         phase   = 1'b0;
      end else begin
         if (prev_ss && !SS_n) begin
            ss_falls++;
            cur = '{len: 0, rises: 0, porch: -1, mosi: 16'h0, bad_period: 0,
                    unstable: 0, gap: cyc - ss_rise_cyc};
            txn_start = cyc;
            last_rise = -1;
            fall_idx  = 0;
            adc_word  = phase ? adc_w2 : adc_w1;
            phase     = ~phase;
         end else if (!prev_ss && SS_n) begin
            cur.len = cyc - txn_start;
            txq.push_back(cur);
            ss_rise_cyc = cyc;
         end else if (!prev_ss && !SS_n) begin
            if (prev_sc && !SCLK) begin
               if (cur.porch < 0) cur.porch = cyc - txn_start;
               if (fall_idx < 16) miso_drv = adc_word[15 - fall_idx];
               fall_idx++;
            end
            if (!prev_sc && SCLK) begin
               cur.rises++;
               cur.mosi = {cur.mosi[14:0], MOSI};
               if (MOSI !== prev_mosi) cur.unstable++;
               if (last_rise >= 0 && (cyc - last_rise) != PERIOD) cur.bad_period++;
               last_rise = cyc;
            end
         end else if (SCLK !== prev_sc) begin
            idle_toggles++;
         end
         prev_ss = SS_n;
         prev_sc = SCLK;
      end
      prev_mosi = MOSI;
   end

   task automatic run_conv(input logic [2:0] ch, input logic [15:0] w2,
                           input int inj_at, input logic [2:0] inj_ch,
                           output int lat, output logic cmplt0,
                           output logic [11:0] res0, output int res_changes);
      int n;
      txq.delete();
      @(negedge clk);
      adc_w1 = 16'($urandom);
      adc_w2 = w2;
      a2d_if.strt_cnv = 1'b1;
      a2d_if.chnnl    = ch;
      @(negedge clk);
      a2d_if.strt_cnv = 1'b0;
      cmplt0 = a2d_if.cnv_cmplt;
      res0   = a2d_if.res;
      res_changes = 0;
      n = 0;
      while (a2d_if.cnv_cmplt !== 1'b1 && n < 2 * CONV_LAT) begin
         @(negedge clk);
         n++;
         if (a2d_if.cnv_cmplt !== 1'b1 && a2d_if.res !== res0) res_changes++;
         a2d_if.chnnl = 3'($urandom);
         if (n == inj_at) begin
            a2d_if.strt_cnv = 1'b1;
            a2d_if.chnnl    = inj_ch;
         end else begin
            a2d_if.strt_cnv = 1'b0;
         end
      end
      a2d_if.strt_cnv = 1'b0;
      lat = (a2d_if.cnv_cmplt === 1'b1) ? n : -1;
      @(negedge clk);
   endtask

   task automatic test_reset;
      int t0, f0;
      rst_n = 1'b0;
      a2d_if.strt_cnv = 1'b0;
      a2d_if.chnnl = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      a2d_if.strt_cnv = 1'b1;
      a2d_if.chnnl = 3'd5;
      @(negedge clk);
      a2d_if.strt_cnv = 1'b0;
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL reset_ss_n got %b exp 1", SS_n); end
      checks++; if (SCLK !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b exp 1", SCLK); end
      checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", MOSI); end
      checks++; if (a2d_if.cnv_cmplt !== 1'b0) begin errors++; $display("FAIL reset_cnv_cmplt got %b exp 0", a2d_if.cnv_cmplt); end
      checks++; if (a2d_if.res !== 12'h000) begin errors++; $display("FAIL reset_res got %h exp 000", a2d_if.res); end
      @(negedge clk);
      rst_n = 1'b1;
      t0 = idle_toggles;
      f0 = ss_falls;
      repeat (100) @(negedge clk);
      checks++; if (idle_toggles != t0) begin errors++; $display("FAIL idle_sclk_toggles got %0d exp 0", idle_toggles - t0); end
      checks++; if (ss_falls != f0) begin errors++; $display("FAIL idle_ss_falls got %0d exp 0", ss_falls - f0); end
   endtask

   task automatic test_basic;
      int lat, rc;
      logic c0;
      logic [11:0] r0;
      logic [15:0] exp_cmd;
      exp_cmd = 16'(32'd4 << 11);
      run_conv(3'h4, 16'h0A5C, -1, 3'h0, lat, c0, r0, rc);
      checks++; if (lat != CONV_LAT) begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, CONV_LAT); end
      checks++; if (a2d_if.res !== 12'hA5C) begin errors++; $display("FAIL basic_res got %h exp a5c", a2d_if.res); end
      checks++; if (txq.size() != 2) begin errors++; $display("FAIL basic_txn_count got %0d exp 2", txq.size()); end
      for (int i = 0; i < txq.size() && i < 2; i++) begin
         checks++; if (txq[i].mosi !== exp_cmd) begin errors++; $display("FAIL basic_mosi%0d got %h exp %h", i, txq[i].mosi, exp_cmd); end
         checks++; if (txq[i].rises != 16) begin errors++; $display("FAIL basic_rises%0d got %0d exp 16", i, txq[i].rises); end
         checks++; if (txq[i].porch != PORCH) begin errors++; $display("FAIL basic_porch%0d got %0d exp %0d", i, txq[i].porch, PORCH); end
         checks++; if (txq[i].len != TXN_CLKS) begin errors++; $display("FAIL basic_len%0d got %0d exp %0d", i, txq[i].len, TXN_CLKS); end
         checks++; if (txq[i].bad_period != 0) begin errors++; $display("FAIL basic_period%0d got %0d bad exp 0", i, txq[i].bad_period); end
         checks++; if (txq[i].unstable != 0) begin errors++; $display("FAIL basic_mosi_stable%0d got %0d exp 0", i, txq[i].unstable); end
      end
      if (txq.size() >= 2) begin
         checks++; if (txq[1].gap != DEAD_CLKS) begin errors++; $display("FAIL basic_dead_gap got %0d exp %0d", txq[1].gap, DEAD_CLKS); end
      end
   endtask

   task automatic test_busy_ignore;
      int lat, rc;
      logic c0;
      logic [11:0] r0;
      logic [15:0] w2;
      w2 = 16'($urandom);
      run_conv(3'h1, w2, 200, 3'h7, lat, c0, r0, rc);
      checks++; if (lat != CONV_LAT) begin errors++; $display("FAIL busy_latency got %0d exp %0d", lat, CONV_LAT); end
      checks++; if (txq.size() != 2) begin errors++; $display("FAIL busy_txn_count got %0d exp 2", txq.size()); end
      for (int i = 0; i < txq.size() && i < 2; i++) begin
         checks++; if (txq[i].mosi !== 16'h0800) begin errors++; $display("FAIL busy_mosi%0d got %h exp 0800", i, txq[i].mosi); end
      end
      checks++; if (a2d_if.res !== w2[11:0]) begin errors++; $display("FAIL busy_res got %h exp %h", a2d_if.res, w2[11:0]); end
   endtask

   task automatic test_back_to_back;
      int lat, rc;
      logic c0;
      logic [11:0] r0;
      logic [15:0] w;
      w = {4'($urandom), 12'h123};
      run_conv(3'($urandom), w, -1, 3'h0, lat, c0, r0, rc);
      checks++; if (a2d_if.res !== 12'h123) begin errors++; $display("FAIL b2b_first_res got %h exp 123", a2d_if.res); end
      w = {4'($urandom), 12'hFFF};
      run_conv(3'h0, w, -1, 3'h0, lat, c0, r0, rc);
      checks++; if (c0 !== 1'b0) begin errors++; $display("FAIL b2b_cmplt_cleared got %b exp 0", c0); end
      checks++; if (r0 !== 12'h123) begin errors++; $display("FAIL b2b_res_held got %h exp 123", r0); end
      checks++; if (rc != 0) begin errors++; $display("FAIL b2b_res_changes got %0d exp 0", rc); end
      checks++; if (lat != CONV_LAT) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", lat, CONV_LAT); end
      checks++; if (a2d_if.res !== 12'hFFF) begin errors++; $display("FAIL b2b_second_res got %h exp fff", a2d_if.res); end
      if (txq.size() >= 1) begin
         checks++; if (txq[0].mosi !== 16'h0000) begin errors++; $display("FAIL b2b_mosi got %h exp 0000", txq[0].mosi); end
      end
   endtask

   task automatic test_random;
      int lat, rc;
      logic c0;
      logic [11:0] r0;
      logic [2:0] ch;
      logic [15:0] w2, exp_cmd;
      for (int k = 0; k < 4; k++) begin
         ch = 3'($urandom);
         w2 = 16'($urandom);
         exp_cmd = 16'(int'(ch) * 2048);
         run_conv(ch, w2, -1, 3'h0, lat, c0, r0, rc);
         checks++; if (a2d_if.res !== w2[11:0]) begin errors++; $display("FAIL rand%0d_res got %h exp %h", k, a2d_if.res, w2[11:0]); end
         checks++; if (lat != CONV_LAT) begin errors++; $display("FAIL rand%0d_latency got %0d exp %0d", k, lat, CONV_LAT); end
         for (int i = 0; i < txq.size() && i < 2; i++) begin
            checks++; if (txq[i].mosi !== exp_cmd) begin errors++; $display("FAIL rand%0d_mosi%0d got %h exp %h", k, i, txq[i].mosi, exp_cmd); end
         end
      end
   endtask

   task automatic test_simultaneous;
      int lat, rc, f0, bad;
      logic c0;
      logic [11:0] r0;
      logic [15:0] w2;
      w2 = 16'($urandom);
      run_conv(3'h2, w2, CONV_LAT - 1, 3'h6, lat, c0, r0, rc);
      checks++; if (lat != CONV_LAT) begin errors++; $display("FAIL simul_latency got %0d exp %0d", lat, CONV_LAT); end
      f0 = ss_falls;
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (a2d_if.cnv_cmplt !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL simul_cmplt_held got %0d low cycles exp 0", bad); end
      checks++; if (ss_falls != f0) begin errors++; $display("FAIL simul_no_restart got %0d falls exp 0", ss_falls - f0); end
      checks++; if (a2d_if.res !== w2[11:0]) begin errors++; $display("FAIL simul_res got %h exp %h", a2d_if.res, w2[11:0]); end
   endtask

   task automatic test_mid_reset;
      int lat, rc, bad;
      logic c0;
      logic [11:0] r0;
      logic [15:0] w2;
      @(negedge clk);
      adc_w1 = 16'($urandom);
      adc_w2 = 16'($urandom);
      a2d_if.strt_cnv = 1'b1;
      a2d_if.chnnl = 3'h3;
      @(negedge clk);
      a2d_if.strt_cnv = 1'b0;
      repeat (TXN_CLKS + DEAD_CLKS + 150) @(negedge clk);
      checks++; if (SS_n !== 1'b0) begin errors++; $display("FAIL midrst_in_txn2 got %b exp 0", SS_n); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL midrst_ss_n got %b exp 1", SS_n); end
      checks++; if (SCLK !== 1'b1) begin errors++; $display("FAIL midrst_sclk got %b exp 1", SCLK); end
      rst_n = 1'b1;
      bad = 0;
      repeat (TXN_CLKS) begin
         @(negedge clk);
         if (a2d_if.cnv_cmplt !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL midrst_cmplt got %0d high cycles exp 0", bad); end
      checks++; if (a2d_if.res !== 12'h000) begin errors++; $display("FAIL midrst_res got %h exp 000", a2d_if.res); end
      w2 = 16'($urandom);
      run_conv(3'h6, w2, -1, 3'h0, lat, c0, r0, rc);
      checks++; if (lat != CONV_LAT) begin errors++; $display("FAIL midrst_fresh_latency got %0d exp %0d", lat, CONV_LAT); end
      checks++; if (a2d_if.res !== w2[11:0]) begin errors++; $display("FAIL midrst_fresh_res got %h exp %h", a2d_if.res, w2[11:0]); end
   endtask

   initial begin
      a2d_if.strt_cnv = 1'b0;
      a2d_if.chnnl = '0;
      test_reset();
      test_basic();
      test_busy_ignore();
      test_back_to_back();
      test_random();
      test_simultaneous();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
